// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: sequences each instruction through fetch, decode,
// execute, memory and writeback, and decodes the datapath strobes from the current state.
module mips_mc_control #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state;
  state_t state_next;
  logic   rdy;
  logic   illegal_q;
  logic   decode_illegal;

  // With MEM_WAIT=0 the memory is assumed single-cycle and mem_ready is ignored.
  assign rdy = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  assign decode_illegal = (state == DECODE) &&
                          (opcode != OP_RTYPE) && (opcode != OP_LW) && (opcode != OP_SW) &&
                          (opcode != OP_BEQ) && (opcode != OP_ADDI) && (opcode != OP_J);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_next;
      illegal_q <= decode_illegal;
    end
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = rdy ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:      state_next = EXEC;
          OP_LW, OP_SW:  state_next = MEMADR;
          OP_BEQ:        state_next = BRANCH;
          OP_ADDI:       state_next = ADDIEX;
          OP_J:          state_next = JUMP;
          default:       state_next = FETCH;
        endcase
      end
      MEMADR: begin
        if (opcode == OP_LW)      state_next = MEMRD;
        else if (opcode == OP_SW) state_next = MEMWR;
        else                      state_next = FETCH;
      end
      MEMRD:  state_next = rdy ? MEMWB : MEMRD;
      MEMWR:  state_next = rdy ? FETCH : MEMWR;
      EXEC:   state_next = ALUWB;
      ADDIEX: state_next = ADDIWB;
      default: state_next = FETCH;
    endcase
  end

  // Strobes are held low throughout reset so an aborted instruction cannot write anything.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    if (!rst) begin
      illegal_op = illegal_q;
      case (state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = rdy;
          pc_write  = rdy;
        end
        DECODE: alu_src_b = 2'b11;
        MEMADR, ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEMWR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        ADDIWB: reg_write = 1'b1;
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: an instruction-level model expands each opcode into
// its expected per-cycle states and strobes; a monitor compares them against the DUT.
module tb_mips_mc_control;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BRANCH = 8, S_ADDIEX = 9,
                 S_ADDIWB = 10, S_JUMP = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic mem_ready = 1'b0;
  logic mem_ready_nw = 1'b0;

  logic pc_write_a, pc_write_cond_a, iord_a, mem_read_a, mem_write_a, ir_write_a;
  logic mem_to_reg_a, reg_dst_a, reg_write_a, alu_src_a_a, illegal_op_a;
  logic [1:0] alu_src_b_a, alu_op_a, pc_source_a;
  logic [3:0] state_a;
  logic pc_write_b, pc_write_cond_b, iord_b, mem_read_b, mem_write_b, ir_write_b;
  logic mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, illegal_op_b;
  logic [1:0] alu_src_b_b, alu_op_b, pc_source_b;
  logic [3:0] state_b;

  mips_mc_control #(.MEM_WAIT(1)) u_wait (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_a), .pc_write_cond(pc_write_cond_a), .iord(iord_a),
    .mem_read(mem_read_a), .mem_write(mem_write_a), .ir_write(ir_write_a),
    .mem_to_reg(mem_to_reg_a), .reg_dst(reg_dst_a), .reg_write(reg_write_a),
    .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a), .alu_op(alu_op_a),
    .pc_source(pc_source_a), .illegal_op(illegal_op_a), .state_o(state_a)
  );

  mips_mc_control #(.MEM_WAIT(0)) u_nowait (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready_nw),
    .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b), .iord(iord_b),
    .mem_read(mem_read_b), .mem_write(mem_write_b), .ir_write(ir_write_b),
    .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b), .reg_write(reg_write_b),
    .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b), .alu_op(alu_op_b),
    .pc_source(pc_source_b), .illegal_op(illegal_op_b), .state_o(state_b)
  );

  always #5 clk = ~clk;

  logic [16:0] outs_a, outs_b;
  assign outs_a = {pc_write_a, pc_write_cond_a, iord_a, mem_read_a, mem_write_a, ir_write_a,
                   mem_to_reg_a, reg_dst_a, reg_write_a, alu_src_a_a, alu_src_b_a, alu_op_a,
                   pc_source_a, illegal_op_a};
  assign outs_b = {pc_write_b, pc_write_cond_b, iord_b, mem_read_b, mem_write_b, ir_write_b,
                   mem_to_reg_b, reg_dst_b, reg_write_b, alu_src_a_b, alu_src_b_b, alu_op_b,
                   pc_source_b, illegal_op_b};

  typedef struct {
    bit          sel;
    int          st;
    logic [16:0] outs;
  } exp_t;

  typedef struct {
    int st;
    bit rdy;
  } ph_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  bit   pend_ill = 1'b0;

  function automatic bit is_legal(logic [5:0] op);
    return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
  endfunction

  // Strobe table per state, packed in the same order as outs_a/outs_b.
  function automatic logic [16:0] exp_out(int st, bit rdy, bit ill, bit r);
    logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa;
    logic [1:0] asb, aop, psrc;
    {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    if (r) return 17'd0;
    case (st)
      S_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
      S_DECODE: asb = 2'b11;
      S_MEMADR, S_ADDIEX: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mr = 1; io = 1; end
      S_MEMWR:  begin mw = 1; io = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_EXEC:   begin asa = 1; aop = 2'b10; end
      S_ALUWB:  begin rw = 1; rd = 1; end
      S_ADDIWB: rw = 1;
      S_BRANCH: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      S_JUMP:   begin pw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction

  task automatic push_cycle(bit sel, int st, bit rdy, bit r, logic [5:0] op);
    exp_t e;
    e.sel  = sel;
    e.st   = st;
    e.outs = exp_out(st, rdy, pend_ill, r);
    sb.push_back(e);
    pend_ill = (!r && st == S_DECODE && !is_legal(op));
  endtask

  task automatic do_reset(bit sel);
    rst = 1'b1;
    @(posedge clk); #1;
    push_cycle(sel, S_FETCH, 1'b0, 1'b1, opcode);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Expands one instruction into its cycle sequence; abort_at asserts rst on that cycle.
  task automatic run_instr(bit sel, logic [5:0] op, int sf, int sm, int abort_at);
    ph_t ph[$];
    bit  r;
    for (int i = 0; i < sf; i++) ph.push_back('{S_FETCH, 1'b0});
    ph.push_back('{S_FETCH, 1'b1});
    ph.push_back('{S_DECODE, 1'b1});
    case (op)
      6'b000000: begin ph.push_back('{S_EXEC, 1'b1}); ph.push_back('{S_ALUWB, 1'b1}); end
      6'b100011: begin
        ph.push_back('{S_MEMADR, 1'b1});
        for (int i = 0; i < sm; i++) ph.push_back('{S_MEMRD, 1'b0});
        ph.push_back('{S_MEMRD, 1'b1});
        ph.push_back('{S_MEMWB, 1'b1});
      end
      6'b101011: begin
        ph.push_back('{S_MEMADR, 1'b1});
        for (int i = 0; i < sm; i++) ph.push_back('{S_MEMWR, 1'b0});
        ph.push_back('{S_MEMWR, 1'b1});
      end
      6'b000100: ph.push_back('{S_BRANCH, 1'b1});
      6'b001000: begin ph.push_back('{S_ADDIEX, 1'b1}); ph.push_back('{S_ADDIWB, 1'b1}); end
      6'b000010: ph.push_back('{S_JUMP, 1'b1});
      default: ;
    endcase
    opcode = op;
    foreach (ph[i]) begin
      r = (i == abort_at);
      rst = r;
      if (ph[i].st == S_FETCH || ph[i].st == S_MEMRD || ph[i].st == S_MEMWR)
        mem_ready = ph[i].rdy;
      else
        mem_ready = 1'($urandom_range(0, 1));
      push_cycle(sel, ph[i].st, sel ? 1'b1 : ph[i].rdy, r, op);
      @(posedge clk); #1;
      rst = 1'b0;
      if (r) break;
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] legal [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] op;
    int k = $urandom_range(0, 7);
    if (k < 6) return legal[k];
    op = 6'($urandom_range(0, 63));
    while (is_legal(op)) op = 6'($urandom_range(0, 63));
    return op;
  endfunction

  exp_t       mon_e;
  logic [3:0] mon_st;
  logic [16:0] mon_o;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e  = sb.pop_front();
      mon_st = mon_e.sel ? state_b : state_a;
      mon_o  = mon_e.sel ? outs_b : outs_a;
      checks++;
      if (mon_st === 4'(mon_e.st)) passed++;
      else $display("FAIL state dut%0d t=%0t: got %0d expected %0d", mon_e.sel, $time, mon_st, mon_e.st);
      checks++;
      if (mon_o === mon_e.outs) passed++;
      else $display("FAIL strobes dut%0d state %0d t=%0t: got %b expected %b",
                    mon_e.sel, mon_e.st, $time, mon_o, mon_e.outs);
    end
  end

  initial begin
    do_reset(1'b0);
    run_instr(0, 6'b000000, 0, 0, -1);
    run_instr(0, 6'b100011, 0, 2, -1);
    run_instr(0, 6'b101011, 1, 1, -1);
    run_instr(0, 6'b000100, 0, 0, -1);
    run_instr(0, 6'b001000, 2, 0, -1);
    run_instr(0, 6'b000010, 0, 0, -1);
    run_instr(0, 6'b111111, 0, 0, -1);
    run_instr(0, 6'b000000, 0, 0, -1);
    run_instr(0, 6'b100011, 0, 0, 4);
    run_instr(0, 6'b000000, 0, 0, 3);
    run_instr(0, 6'b111111, 0, 0, -1);
    run_instr(0, 6'b000010, 0, 0, 0);
    for (int n = 0; n < 200; n++)
      run_instr(0, rand_op(), $urandom_range(0, 2), $urandom_range(0, 2),
                ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : -1);

    mem_ready = 1'b0;
    do_reset(1'b1);
    run_instr(1, 6'b100011, 0, 0, -1);
    run_instr(1, 6'b101011, 0, 0, -1);
    run_instr(1, 6'b000000, 0, 0, -1);
    for (int n = 0; n < 30; n++)
      run_instr(1, rand_op(), 0, 0, -1);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expected cycles left unchecked, required 0", sb.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
